mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide unit for the MIPS core. Executes MULT, MULTU, DIV and DIVU and holds the HI/LO results.
- Computes one partial step per cycle over 32 cycles, reusing a single 32-bit adder.
- Subtraction is done by inverting the B operand and forcing carry-in (an XOR-with-control inverter), with the sequencer driving that control bit.
- Sits beside the ALU in EX. The core stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the step counter is sized log2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- busy  out  1  high from the cycle after start is accepted through FIX
- done  out  1  one-cycle pulse; hi/lo valid from this cycle
- div_by_zero  out  1  pulses with done when a divide had b==0
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, step counter=0.
- States and transitions:
  - IDLE: on start=1, latch op, a and b; go to PREP. start is ignored in every other state.
  - PREP (1 cycle): for signed ops, take the absolute value of each operand and record the result sign and the remainder sign (the remainder sign equals the dividend sign). For a DIV/DIVU with b==0, set the zero flag and go to FIX.
  - RUN (32 cycles, counter 0..31):
    - Multiply: shift-add. If multiplier LSB=1, add the multiplicand to the upper accumulator; then shift the 64-bit accumulator right by 1, with the carry shifting in.
    - Divide: restoring. Shift the remainder:quotient pair left by 1 and trial-subtract the divisor (adder control=1, B inverted, carry-in=1). If no borrow, keep the difference and set quotient bit=1; otherwise restore and set the bit to 0.
    - Exit to FIX when counter==31.
  - FIX (1 cycle):
    - Apply sign correction by two's-complement negation: for MULT, negate the 64-bit product if the signs differ; for DIV, negate the quotient if the signs differ and the remainder if the dividend was negative.
    - Write hi/lo.
    - Divide by zero: lo=32'hFFFF_FFFF, hi=a (as latched, unmodified), div_by_zero=1 in DONE.
  - DONE (1 cycle): done=1, busy=0; then return to IDLE.
- Latency:
  - start is sampled at edge E. PREP occupies cycle E+1, RUN cycles E+2..E+33, FIX cycle E+34, and done=1 in cycle E+35.
  - Divide by zero: done in cycle E+3.
- Result hold: hi/lo update only in FIX. They hold otherwise, including while busy, so the core sees the previous results until done.
- Back-to-back operation: start asserted in the DONE cycle is ignored. A new request is accepted in IDLE, at the earliest the cycle after DONE.
- DIV overflow case: 32'h8000_0000 / -1 gives lo=32'h8000_0000, hi=0 (natural wrap, no flag).
- Reset mid-operation: immediate return to IDLE, all outputs take their reset values, and the in-flight result is discarded.
- Unsigned ops: no sign correction; FIX still takes 1 cycle so latency stays uniform.

Optional Feature:
- Macro: MDU_DIV_EN.
- Defined: full divide support as above.
- Undefined: the divide path and restore logic are removed. A DIV/DIVU start goes from IDLE straight to DONE (done in cycle E+1) with hi/lo unchanged and div_by_zero=1, used as the unsupported-op flag. Multiply behaviour is unchanged.

Decomposition:
- Shared package mdu_pkg:
  - op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - state enum (IDLE, PREP, RUN, FIX, DONE)
  - STEPS=32
- One sub-module: mdu_addsub, a 32-bit adder with inv_b control. It XORs B with inv_b and uses inv_b as carry-in, and provides carry_out for the borrow test. It is instanced once and driven by the sequencer.

Test Plan:
- MULTU a=7, b=6 -> busy cycles E+1..E+34; done at E+35; lo=32'h0000_002A, hi=0.
- MULT a=-3 (FFFF_FFFD), b=5 -> lo=FFFF_FFF1, hi=FFFF_FFFF.
- DIV a=-7, b=2 -> lo=FFFF_FFFD (-3), hi=FFFF_FFFF (-1); DIVU a=FFFF_FFFF, b=1 -> lo=FFFF_FFFF, hi=0.
- DIV a=32'h1234, b=0 -> done at E+3, div_by_zero=1, lo=FFFF_FFFF, hi=32'h1234.
- MULTU 3*3 started, second start at E+10 with different operands -> ignored; result 9; hi/lo keep their old values until E+34.
- reset asserted at E+20 mid-DIV -> next cycle IDLE, busy=0, hi=lo=0; a new MULTU 2*2 then completes with lo=4.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, state encoding, step count.
package mdu_pkg;

  localparam int STEPS = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/mdu_addsub.sv
// Shared adder for the MDU; inv_b_i turns it into a subtractor (B inverted, carry-in forced).
module mdu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             inv_b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] b_x;

  assign b_x = b_i ^ {WIDTH{inv_b_i}};
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, inv_b_i};

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO. Divide support is built only when
// MDU_DIV_EN is defined; otherwise divide ops complete immediately with div_by_zero flagging them.
//
// state | meaning
// IDLE  | waiting for start, operands latched on accept
// PREP  | take operand magnitudes, record result/remainder signs, detect b==0
// RUN   | 32 shift-add / restoring-subtract steps
// FIX   | sign correction, write hi/lo
// DONE  | done pulse, back to IDLE
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, mc_q, mc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic               sgn, is_div, inv_b, add_co;
  logic [WIDTH-1:0]   a_abs, b_abs, add_a, add_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;

  assign sgn      = op_q[0];
  assign a_abs    = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs    = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign mul_next = acc_q[0] ? {add_co, add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic               negr_q, negr_d, dz_q, dz_d, take;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div = op_q[1];
  assign inv_b  = is_div;
  assign add_a  = is_div ? acc_q[2*WIDTH-2:WIDTH-1] : acc_q[2*WIDTH-1:WIDTH];
  // A set bit shifted out of the remainder means it already exceeds any divisor.
  assign take     = acc_q[2*WIDTH-1] | add_co;
  assign div_next = {take ? add_sum : acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], take};
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign div_by_zero = (state_q == S_DONE) && dz_q;
`else
  assign is_div = 1'b0;
  assign inv_b  = 1'b0;
  assign add_a  = acc_q[2*WIDTH-1:WIDTH];
  assign div_by_zero = (state_q == S_DONE) && op_q[1];
`endif

  mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i     (add_a),
    .b_i     (mc_q),
    .inv_b_i (inv_b),
    .sum_o   (add_sum),
    .carry_o (add_co)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    negr_d  = negr_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
`ifdef MDU_DIV_EN
          dz_d    = 1'b0;
          state_d = S_PREP;
`else
          state_d = op[1] ? S_DONE : S_PREP;
`endif
        end
      end
      S_PREP: begin
        neg_d   = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        cnt_d   = '0;
        state_d = S_RUN;
        mc_d    = a_abs;
        acc_d   = {{WIDTH{1'b0}}, b_abs};
`ifdef MDU_DIV_EN
        negr_d = sgn && a_q[WIDTH-1];
        if (is_div) begin
          mc_d  = b_abs;
          acc_d = {{WIDTH{1'b0}}, a_abs};
          if (b_q == '0) begin
            dz_d    = 1'b1;
            state_d = S_FIX;
          end
        end
`endif
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = mul_next;
`ifdef MDU_DIV_EN
        if (is_div) acc_d = div_next;
`endif
        if (cnt_q == CW'(STEPS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div) begin
          hi_d = dz_q ? a_q : rem_fix;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
        end
`endif
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      negr_q  <= negr_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer; expectations follow MDU_DIV_EN when it is defined.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_hi = '0, prev_lo = '0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    e.dz  = 1'b0;
    e.lat = 35;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
`ifdef MDU_DIV_EN
        if (y == 32'd0) begin
          e.dz = 1'b1; e.lat = 3; e.lo = 32'hFFFF_FFFF; e.hi = x;
        end else if (o == 2'b10) begin
          e.lo = x / y; e.hi = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0];
        end
`else
        e.dz = 1'b1; e.lat = 1; e.hi = prev_hi; e.lo = prev_lo;
`endif
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; leaves the bench at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke);
    exp_t e;
    bit   seen, busy_ok, hold_ok;
    int   k;
    sb.push_back(model(o, x, y));
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    seen = 0; busy_ok = 1; hold_ok = 1; k = 0;
    while (!seen && k < 60) begin
      k++;
      @(negedge clk);
      if (k == poke) begin start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100; end
      else start = 1'b0;
      if (done === 1'b1) begin
        seen = 1;
        e = sb.pop_front();
        checks++; if (k !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, k, e.lat); end
        checks++; if (hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, e.hi); end
        checks++; if (lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, e.lo); end
        checks++; if (dz !== e.dz) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", name, dz, e.dz); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
        prev_hi = e.hi; prev_lo = e.lo;
      end else begin
        if (busy !== 1'b1 || dz !== 1'b0) busy_ok = 0;
        if (hi !== prev_hi || lo !== prev_lo) hold_ok = 0;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s done_timeout: got no done in %0d cycles want done", name, k);
      void'(sb.pop_front());
    end
    checks++; if (!busy_ok) begin errors++; $display("FAIL %s busy_window: got gap want busy=1 until done", name); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL %s hold: got hi/lo change while busy want %h/%h", name, prev_hi, prev_lo); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got busy=%b done=%b want 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      errors++; $display("FAIL reset_hold: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, dz, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      errors++; $display("FAIL reset_release: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, dz, hi, lo);
    end
  endtask

  task automatic test_mul();
    run_op("multu_7x6", 2'b00, 32'd7, 32'd6, 0);
    run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 0);
    run_op("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("multu_max_sq", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_m1xm1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_div();
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0);
    run_op("divu_big", 2'b10, 32'hFFFF_FFFE, 32'h8000_0001, 0);
  endtask

  task automatic test_div_zero();
    run_op("div_1234_0", 2'b11, 32'h0000_1234, 32'd0, 0);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 0);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mid_start", 2'b00, 32'd3, 32'd3, 10);
    run_op("b2b_done_start", 2'b00, 32'd5, 32'd6, 35);
    run_op("b2b_next", 2'b00, 32'd2, 32'd3, 0);
  endtask

  task automatic test_reset_mid();
    bit was_busy;
`ifdef MDU_DIV_EN
    start = 1'b1; op = 2'b11;
`else
    start = 1'b1; op = 2'b01;
`endif
    a = 32'hFFFF_FF9C; b = 32'd7;
    @(posedge clk);
    was_busy = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) was_busy = 0;
    end
    checks++; if (!was_busy) begin errors++; $display("FAIL rst_mid_busy: got busy gap want busy=1 before reset"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, dz, hi, lo);
    end
    reset = 1'b0;
    prev_hi = '0; prev_lo = '0;
    run_op("rst_mid_multu_2x2", 2'b00, 32'd2, 32'd2, 0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
